// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory port arbiter: default widths and response-owner encoding.
// No logic, so there is no latency.
// No handshake of its own, so it applies no backpressure.
package imem_pkg;
    localparam int IMEM_ADDR_W        = 6;
    localparam int IMEM_DATA_W        = 32;
    localparam int IMEM_STARVE_LIMIT  = 4;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE  = 2'd0;
    localparam owner_t OWN_FETCH = 2'd1;
    localparam owner_t OWN_LOAD  = 2'd2;
endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating starvation counter: counts denied fetch cycles up to LIMIT and flags when the limit is reached.
// at_limit is combinational from the registered count.
// No handshake: the count saturates at LIMIT rather than stalling anything.
module imem_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_W'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == CNT_W'(LIMIT));
endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between CPU fetch and the program loader; build option IMEM_BOOT_HOLD_EN.
// Grant is combinational; the read response arrives 1 cycle after the grant.
// A requester that is not granted simply holds its request; a starved fetch is forced to win after STARVE_LIMIT cycles.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W       = IMEM_ADDR_W,
    parameter int DATA_W       = IMEM_DATA_W,
    parameter int STARVE_LIMIT = IMEM_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_boot_done,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic        boot_ok;
    logic        at_limit;
    logic [31:0] sel_addr;
    logic        in_range;
    owner_t      owner_q;
    logic        err_q;
    logic [DATA_W-1:0] rdata_mux;

`ifdef IMEM_BOOT_HOLD_EN
    logic boot_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            boot_q <= 1'b0;
        end else if (ld_boot_done) begin
            boot_q <= 1'b1;
        end
    end

    assign boot_ok = boot_q;
`else
    logic unused_boot_done;

    assign unused_boot_done = ld_boot_done;
    assign boot_ok          = 1'b1;
`endif

    // Grants are gated by reset_n so nothing is accepted while reset is held.
    always_comb begin
        if_gnt = reset_n && boot_ok && if_req && (!ld_req || at_limit);
        ld_gnt = reset_n && ld_req && !(if_req && boot_ok && at_limit);
    end

    imem_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clock    (clock),
        .reset_n  (reset_n),
        .inc      (if_req && !if_gnt),
        .clr      (if_gnt || !if_req || !boot_ok),
        .at_limit (at_limit)
    );

    always_comb begin
        sel_addr = 32'd0;
        if (if_gnt) begin
            sel_addr = if_addr;
        end else if (ld_gnt) begin
            sel_addr = ld_addr;
        end
    end

    assign in_range  = (sel_addr[31:ADDR_W] == '0);
    assign mem_addr  = sel_addr[ADDR_W-1:0];
    assign mem_we    = ld_gnt && ld_we && in_range;
    assign mem_wdata = ld_wdata;

    // Writes leave owner_q at NONE but still flag out-of-range via err_q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
        end else begin
            err_q <= (if_gnt || ld_gnt) && !in_range;
            if (if_gnt) begin
                owner_q <= OWN_FETCH;
            end else if (ld_gnt && !ld_we) begin
                owner_q <= OWN_LOAD;
            end else begin
                owner_q <= OWN_NONE;
            end
        end
    end

    assign rdata_mux = err_q ? '0 : mem_rdata;
    assign if_rvalid = (owner_q == OWN_FETCH);
    assign ld_rvalid = (owner_q == OWN_LOAD);
    assign if_rdata  = rdata_mux;
    assign ld_rdata  = rdata_mux;
    assign resp_err  = err_q;
endmodule
